// File: rtl/tty_host_ctl.sv
// -----------------------------------------------------------------------------
// tty_host_ctl
//   CPU-side initiator for the byte-wide UART handshake used by the PDP-8
//   console TTY device. Single-cycle IOT strobes (TLS, TCF, KRB) become
//   request/acknowledge sequences toward the UART. The block also keeps the
//   KL8E-style printer/keyboard flags, the receive buffer and the interrupt
//   request.
//
//   Optional feature macro: TTY_IRQ_EN
//     defined   - interrupt-enable register written by io_ie_wr;
//                 irq = ie & (tx_flag | rx_flag), registered (1-cycle latency)
//     undefined - no ie register, irq tied low, io_ie_wr/io_ie_data unused
//
//   The reset input is asynchronous and active low.
// -----------------------------------------------------------------------------
module tty_host_ctl #(
  parameter int TX_GUARD = 2,   // cycles to wait for tx_empty to fall (min 1)
  parameter int DATA_W   = 8    // character width
) (
  input  logic              clk,
  input  logic              reset,
  // IOT decode side
  input  logic              io_tx_load,
  input  logic [DATA_W-1:0] io_tx_data,
  input  logic              io_tx_clrflag,
  input  logic              io_rx_read,
  input  logic              io_ie_wr,
  input  logic              io_ie_data,
  // UART transmit handshake
  output logic              tx_req,
  input  logic              tx_ack,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_empty,
  // UART receive handshake
  output logic              rx_req,
  input  logic              rx_ack,
  input  logic              rx_empty,
  input  logic [DATA_W-1:0] rx_data,
  // TTY status toward the CPU
  output logic              tx_flag,
  output logic              rx_flag,
  output logic [DATA_W-1:0] rx_buf,
  output logic              tx_busy,
  output logic              irq
);

  // A guard of zero would never expire, so it is clamped to one.
  localparam int GUARD_LD = (TX_GUARD < 1) ? 1 : TX_GUARD;
  localparam int GUARD_W  = (GUARD_LD < 2) ? 1 : $clog2(GUARD_LD + 1);

  typedef enum logic [1:0] {
    T_IDLE  = 2'd0,
    T_REQ   = 2'd1,
    T_WAIT  = 2'd2,
    T_DRAIN = 2'd3
  } tx_state_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_CAPT = 2'd2
  } rx_state_t;

  tx_state_t          tx_state;
  rx_state_t          rx_state;
  logic [GUARD_W-1:0] guard;

  // ---------------------------------------------------------------------------
  // Request lines and busy are pure decodes of the registered state, so they
  // are glitch-free and drop the cycle after the ack is sampled.
  // ---------------------------------------------------------------------------
  assign tx_req  = (tx_state == T_REQ);
  assign rx_req  = (rx_state == R_REQ);
  assign tx_busy = (tx_state != T_IDLE);

  // ---------------------------------------------------------------------------
  // Transmit FSM: load character, request, then wait for the UART to finish.
  // ---------------------------------------------------------------------------
  // If the UART never drops tx_empty within the guard window (very fast
  // transmitter, or a model that completes instantly), the character is
  // treated as already sent.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_state <= T_IDLE;
      tx_data  <= '0;
      tx_flag  <= 1'b0;
      guard    <= '0;
    end else begin
      // NOTE: non-blocking assignments to the same register in one block
      // resolve to the last one executed, so the FSM's flag set below wins
      // over this clear when both happen in the same cycle.
      if (io_tx_clrflag) begin
        tx_flag <= 1'b0;
      end

      case (tx_state)
        T_IDLE: begin
          if (io_tx_load) begin
            tx_data  <= io_tx_data;
            tx_flag  <= 1'b0;
            tx_state <= T_REQ;
          end
        end

        T_REQ: begin
          if (tx_ack) begin
            guard    <= GUARD_W'(GUARD_LD);
            tx_state <= T_WAIT;
          end
        end

        T_WAIT: begin
          if (!tx_empty) begin
            tx_state <= T_DRAIN;
          end else if (guard == GUARD_W'(1)) begin
            tx_flag  <= 1'b1;
            tx_state <= T_IDLE;
          end else begin
            guard <= guard - GUARD_W'(1);
          end
        end

        T_DRAIN: begin
          if (tx_empty) begin
            tx_flag  <= 1'b1;
            tx_state <= T_IDLE;
          end
        end

        default: tx_state <= T_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM: fetch one character whenever the buffer is free.
  // ---------------------------------------------------------------------------
  // No request is issued while rx_flag is set, so an unread character can
  // never be overwritten. A CPU read coinciding with a capture loses to the
  // capture, so the new character stays flagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_state <= R_IDLE;
      rx_buf   <= '0;
      rx_flag  <= 1'b0;
    end else begin
      if (io_rx_read) begin
        rx_flag <= 1'b0;
      end

      case (rx_state)
        R_IDLE: begin
          if (!rx_flag && !rx_empty) begin
            rx_state <= R_REQ;
          end
        end

        R_REQ: begin
          if (rx_ack) begin
            rx_state <= R_CAPT;
          end
        end

        R_CAPT: begin
          // rx_data is valid in the cycle after rx_ack, i.e. this one.
          rx_buf   <= rx_data;
          rx_flag  <= 1'b1;
          rx_state <= R_IDLE;
        end

        default: rx_state <= R_IDLE;
      endcase
    end
  end

`ifdef TTY_IRQ_EN
  logic ie;

  // Interrupt enable register and registered interrupt request.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (io_ie_wr) begin
        ie <= io_ie_data;
      end
      irq <= ie & (tx_flag | rx_flag);
    end
  end
`else
  // Interrupts are not built; the enable write port is left unconnected.
  logic unused_ie;
  assign unused_ie = io_ie_wr ^ io_ie_data;
  assign irq       = 1'b0;
`endif

endmodule

// File: tb/tb_tty_host_ctl.sv
// -----------------------------------------------------------------------------
// tb_tty_host_ctl
//   Directed self-checking bench for tty_host_ctl. The UART responder is
//   played inline by the stimulus sequence. Outputs are sampled 1 time unit
//   after the rising edge. Build with +define+TTY_IRQ_EN to exercise the
//   interrupt path.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tty_host_ctl;

  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              io_tx_load;
  logic [DATA_W-1:0] io_tx_data;
  logic              io_tx_clrflag;
  logic              io_rx_read;
  logic              io_ie_wr;
  logic              io_ie_data;
  logic              tx_req;
  logic              tx_ack;
  logic [DATA_W-1:0] tx_data;
  logic              tx_empty;
  logic              rx_req;
  logic              rx_ack;
  logic              rx_empty;
  logic [DATA_W-1:0] rx_data;
  logic              tx_flag;
  logic              rx_flag;
  logic [DATA_W-1:0] rx_buf;
  logic              tx_busy;
  logic              irq;

  int n_checks = 0;
  int n_fail   = 0;

  tty_host_ctl #(.TX_GUARD(2), .DATA_W(DATA_W)) dut (
    .clk           (clk),
    .reset         (reset),
    .io_tx_load    (io_tx_load),
    .io_tx_data    (io_tx_data),
    .io_tx_clrflag (io_tx_clrflag),
    .io_rx_read    (io_rx_read),
    .io_ie_wr      (io_ie_wr),
    .io_ie_data    (io_ie_data),
    .tx_req        (tx_req),
    .tx_ack        (tx_ack),
    .tx_data       (tx_data),
    .tx_empty      (tx_empty),
    .rx_req        (rx_req),
    .rx_ack        (rx_ack),
    .rx_empty      (rx_empty),
    .rx_data       (rx_data),
    .tx_flag       (tx_flag),
    .rx_flag       (rx_flag),
    .rx_buf        (rx_buf),
    .tx_busy       (tx_busy),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  // Hard stop in case a sequence runs away.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 unit past the edge.
  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait (bounded) until rx_req is high; reports a failure on timeout.
  task automatic wait_rx_req(input string tag);
    int k;
    k = 0;
    while (rx_req !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    if (rx_req !== 1'b1) check(tag, rx_req, 1);
  endtask

  // "LOGIN 2 LXHE" followed by two 0215 (CR with mark parity).
  logic [7:0] login_q [14] = '{8'h4C, 8'h4F, 8'h47, 8'h49, 8'h4E, 8'h20, 8'h32,
                               8'h20, 8'h4C, 8'h58, 8'h48, 8'h45, 8'h8D, 8'h8D};
  logic [7:0] got_q [14];
  int         n_req_high;

  initial begin
    reset         = 1'b0;
    io_tx_load    = 1'b0;
    io_tx_data    = '0;
    io_tx_clrflag = 1'b0;
    io_rx_read    = 1'b0;
    io_ie_wr      = 1'b0;
    io_ie_data    = 1'b0;
    tx_ack        = 1'b0;
    tx_empty      = 1'b1;
    rx_ack        = 1'b0;
    rx_empty      = 1'b1;
    rx_data       = '0;

    // ---------------- reset state ----------------
    step(3);
    check("rst_tx_req",  tx_req,  0);
    check("rst_rx_req",  rx_req,  0);
    check("rst_tx_data", tx_data, 0);
    check("rst_rx_buf",  rx_buf,  0);
    check("rst_tx_flag", tx_flag, 0);
    check("rst_rx_flag", rx_flag, 0);
    check("rst_tx_busy", tx_busy, 0);
    check("rst_irq",     irq,     0);
    reset = 1'b1;
    step();

`ifdef TTY_IRQ_EN
    io_ie_wr   = 1'b1;
    io_ie_data = 1'b1;
    step();
    io_ie_wr   = 1'b0;
    io_ie_data = 1'b0;
`endif

    // ---------------- TX 0x41, UART drains for 38 cycles ----------------
    io_tx_load = 1'b1;
    io_tx_data = 8'h41;
    step();
    io_tx_load = 1'b0;
    io_tx_data = 8'h00;
    check("tx1_req_latency", tx_req,  1);
    check("tx1_data",        tx_data, 8'h41);
    check("tx1_busy",        tx_busy, 1);
    tx_ack = 1'b1;
    step();
    tx_ack   = 1'b0;
    tx_empty = 1'b0;
    check("tx1_req_drop", tx_req, 0);
    step(37);
    check("tx1_flag_drain", tx_flag, 0);
    check("tx1_busy_drain", tx_busy, 1);
    step();
    tx_empty = 1'b1;
    step();
    check("tx1_flag_done", tx_flag, 1);
    check("tx1_idle",      tx_busy, 0);
    io_tx_clrflag = 1'b1;
    step();
    io_tx_clrflag = 1'b0;
    check("tcf_clear", tx_flag, 0);

    // ---------------- TX 0x0D, tx_empty never falls (guard) ----------------
    io_tx_load = 1'b1;
    io_tx_data = 8'h0D;
    step();
    io_tx_load = 1'b0;
    check("tx2_req", tx_req, 1);
    tx_ack = 1'b1;
    step();
    tx_ack = 1'b0;
    check("tx2_flag_g0", tx_flag, 0);
    step();
    check("tx2_flag_g1", tx_flag, 0);
    io_tx_clrflag = 1'b1;                // coincides with the flag set
    step();
    io_tx_clrflag = 1'b0;
    check("tx2_flag_set_wins", tx_flag, 1);
    check("tx2_idle",          tx_busy, 0);
    check("tx2_data",          tx_data, 8'h0D);

    // ---------------- TX load while busy is ignored ----------------
    io_tx_load = 1'b1;
    io_tx_data = 8'h33;
    step();
    check("busy_load_clears_flag", tx_flag, 0);
    check("busy_first_data",       tx_data, 8'h33);
    io_tx_data = 8'h55;                  // second load while in T_REQ
    step();
    io_tx_load = 1'b0;
    check("busy_data_kept_req", tx_data, 8'h33);
    check("busy_req_held",      tx_req,  1);
    tx_ack = 1'b1;
    step();
    tx_ack     = 1'b0;
    io_tx_load = 1'b1;                   // another load while in T_WAIT
    io_tx_data = 8'h55;
    n_req_high = 0;
    step();
    io_tx_load = 1'b0;
    if (tx_req) n_req_high++;
    step();
    if (tx_req) n_req_high++;
    check("busy_no_second_req", n_req_high, 0);
    check("busy_data_kept",     tx_data, 8'h33);
    check("busy_flag_done",     tx_flag, 1);
    check("busy_idle",          tx_busy, 0);
    io_tx_clrflag = 1'b1;
    step();
    io_tx_clrflag = 1'b0;

    // ---------------- RX single byte 0xD3 ----------------
    rx_empty = 1'b0;
    step();
    check("rx1_req_latency", rx_req, 1);
    rx_ack = 1'b1;
    step();
    rx_ack  = 1'b0;
    rx_data = 8'hD3;
    check("rx1_req_drop",   rx_req,  0);
    check("rx1_flag_early", rx_flag, 0);
    step();
    rx_data = 8'h00;
    check("rx1_flag", rx_flag, 1);
    check("rx1_buf",  rx_buf,  8'hD3);
    n_req_high = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (rx_req) n_req_high++;
    end
    check("rx1_no_req_while_flag", n_req_high, 0);
`ifdef TTY_IRQ_EN
    check("irq_on_rx", irq, 1);
`else
    check("irq_tied_low", irq, 0);
`endif
    rx_empty   = 1'b1;
    io_rx_read = 1'b1;
    step();
    io_rx_read = 1'b0;
    check("rx1_read_clears", rx_flag, 0);
    check("rx1_buf_held",    rx_buf,  8'hD3);
    step();
    check("irq_after_read", irq, 0);

    // ---------------- RX queue of 14 bytes ----------------
    rx_empty = 1'b0;
    for (int i = 0; i < 14; i++) begin
      wait_rx_req("rxq_req_timeout");
      rx_ack = 1'b1;
      step();
      rx_ack  = 1'b0;
      rx_data = login_q[i];
      step();
      rx_data = 8'h00;
      got_q[i] = rx_flag ? rx_buf : 8'hFF;
      io_rx_read = 1'b1;
      step();
      io_rx_read = 1'b0;
    end
    rx_empty = 1'b1;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("rxq_byte%0d", i), got_q[i], login_q[i]);
    end

    // ---------------- RX read coinciding with capture ----------------
    step();
    rx_empty = 1'b0;
    wait_rx_req("rxc_req_timeout");
    rx_ack = 1'b1;
    step();
    rx_ack     = 1'b0;
    rx_empty   = 1'b1;
    rx_data    = 8'h7E;
    io_rx_read = 1'b1;
    step();
    io_rx_read = 1'b0;
    rx_data    = 8'h00;
    check("rxc_set_wins", rx_flag, 1);
    check("rxc_buf",      rx_buf,  8'h7E);
    io_rx_read = 1'b1;
    step();
    io_rx_read = 1'b0;
    check("rxc_read", rx_flag, 0);

    // ---------------- reset mid-handshake ----------------
    io_tx_load = 1'b1;
    io_tx_data = 8'h22;
    rx_empty   = 1'b0;
    step();
    io_tx_load = 1'b0;
    check("mid_tx_req", tx_req, 1);
    check("mid_rx_req", rx_req, 1);
    tx_ack = 1'b1;
    rx_ack = 1'b1;
    reset  = 1'b0;
    #1;
    check("mid_rst_tx_req",  tx_req,  0);
    check("mid_rst_rx_req",  rx_req,  0);
    check("mid_rst_tx_data", tx_data, 0);
    check("mid_rst_busy",    tx_busy, 0);
    step();
    reset    = 1'b1;
    rx_empty = 1'b1;
    step();
    check("post_rst_tx_req",  tx_req,  0);
    check("post_rst_rx_req",  rx_req,  0);
    check("post_rst_busy",    tx_busy, 0);
    check("post_rst_rx_flag", rx_flag, 0);
    tx_ack = 1'b0;
    rx_ack = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
